ace_snapshot_unpacker: RTL and testbench

- Sits between the mist_io ioctl download port and the jupiter_ace loader port.
- Converts a streamed .ACE snapshot, RLE-compressed with escape byte 0xED, into plain sequential RAM writes starting at BASE_ADDR.
- Stalls the ioctl stream with ioctl_wait while it expands a run.
- Reports end-of-image, overflow and protocol errors for LEDs and status.

---
 rtl/ace_snapshot_unpacker_pkg.sv | 17 +
 rtl/ace_snapshot_unpacker.sv | 164 ++++++++++++++++
 tb/tb_ace_snapshot_unpacker.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ace_snapshot_unpacker_pkg.sv
// Shared types and constants for the Jupiter ACE snapshot unpacker.
package ace_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LIT     = 3'd1,
        GOT_ESC = 3'd2,
        GOT_CNT = 3'd3,
        RUN     = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [7:0]  ACE_ESC      = 8'hED;
    localparam logic [15:0] ACE_RAM_BASE = 16'h2000;
    localparam logic [15:0] ACE_RAM_LEN  = 16'h6000;

endpackage

// File: rtl/ace_snapshot_unpacker.sv
// Expands an RLE-compressed .ACE snapshot arriving on the ioctl download port
// into sequential loader RAM writes, stalling the stream while a run expands.
module ace_snapshot_unpacker
    import ace_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = ACE_RAM_BASE,
    parameter logic [15:0] MAX_LEN   = ACE_RAM_LEN,
    parameter logic [7:0]  ESC       = ACE_ESC
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        loader_en,
    output logic [15:0] loader_addr,
    output logic [7:0]  loader_data,
    output logic        loader_wr,
    output logic        done,
    output logic        overflow,
    output logic        proto_err
);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;     // run length latched from the count byte
    logic [7:0]  run_q, run_d;     // writes still to issue in the current run
    logic [7:0]  val_q, val_d;     // byte being repeated by the current run
    logic        dl_rise, dl_fall;

    logic        wr_d, wait_d, done_d, ovf_d, perr_d;
    logic [7:0]  data_d;
    logic [15:0] addr_d;
    logic        wr_req;
    logic [7:0]  wr_byte;

    // loader_en doubles as the delayed download flag for edge detection
    assign dl_rise = ioctl_download & ~loader_en;
    assign dl_fall = ~ioctl_download & loader_en;

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode; download edges override the decoder
    always_comb begin
        state_d = state_q;
        if (dl_rise) begin
            state_d = LIT;
        end else if (dl_fall) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                LIT:     if (ioctl_wr && ioctl_dout == ESC) state_d = GOT_ESC;
                GOT_ESC: if (ioctl_wr) state_d = (ioctl_dout == 8'h00) ? DONE : GOT_CNT;
                GOT_CNT: if (ioctl_wr) state_d = RUN;
                RUN:     if (run_q == 8'd0) state_d = LIT;
                default: state_d = state_q;
            endcase
        end
    end

    // Output and datapath next values; a write request is suppressed once
    // the output window is full, in which case the address holds
    always_comb begin
        wr_d    = 1'b0;
        wait_d  = 1'b0;
        data_d  = loader_data;
        addr_d  = loader_addr + {15'd0, loader_wr};
        done_d  = done;
        ovf_d   = overflow;
        perr_d  = proto_err;
        cnt_d   = cnt_q;
        run_d   = run_q;
        val_d   = val_q;
        wr_req  = 1'b0;
        wr_byte = val_q;

        if (dl_rise) begin
            addr_d = BASE_ADDR;
            done_d = 1'b0;
            ovf_d  = 1'b0;
            perr_d = 1'b0;
        end else if (dl_fall) begin
            if (state_q == GOT_ESC || state_q == GOT_CNT || state_q == RUN)
                perr_d = 1'b1;
        end else begin
            // a byte offered while stalled is lost
            if (ioctl_wr && ioctl_wait) perr_d = 1'b1;
            case (state_q)
                LIT: begin
                    if (ioctl_wr && ioctl_dout != ESC) begin
                        wr_req  = 1'b1;
                        wr_byte = ioctl_dout;
                    end
                end
                GOT_ESC: begin
                    if (ioctl_wr) begin
                        if (ioctl_dout == 8'h00) done_d = 1'b1;
                        else                     cnt_d  = ioctl_dout;
                    end
                end
                GOT_CNT: begin
                    if (ioctl_wr) begin
                        wr_req  = 1'b1;
                        wr_byte = ioctl_dout;
                        val_d   = ioctl_dout;
                        run_d   = cnt_q - 8'd1;
                        wait_d  = 1'b1;
                    end
                end
                RUN: begin
                    if (run_q != 8'd0) begin
                        wr_req = 1'b1;
                        run_d  = run_q - 8'd1;
                        wait_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (wr_req) begin
            if ((addr_d - BASE_ADDR) == MAX_LEN) begin
                ovf_d = 1'b1;
            end else begin
                wr_d   = 1'b1;
                data_d = wr_byte;
            end
        end
    end

    // Registered outputs and run bookkeeping
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ioctl_wait  <= 1'b0;
            loader_en   <= 1'b0;
            loader_addr <= BASE_ADDR;
            loader_data <= 8'h00;
            loader_wr   <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
            cnt_q       <= 8'h00;
            run_q       <= 8'h00;
            val_q       <= 8'h00;
        end else begin
            ioctl_wait  <= wait_d;
            loader_en   <= ioctl_download;
            loader_addr <= addr_d;
            loader_data <= data_d;
            loader_wr   <= wr_d;
            done        <= done_d;
            overflow    <= ovf_d;
            proto_err   <= perr_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            val_q       <= val_d;
        end
    end

endmodule

// File: tb/tb_ace_snapshot_unpacker.sv
// Scoreboard bench: token-level stream generator predicts every RAM write
// (cycle, address, data) and stall window; monitors compare on each strobe.
module tb_ace_snapshot_unpacker;
    import ace_pkg::*;

    localparam logic [15:0] SMAX = 16'd4;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'h00;

    logic        a_wait, a_en, a_wr, a_done, a_ovf, a_perr;
    logic [15:0] a_addr;
    logic [7:0]  a_data;
    logic        b_wait, b_en, b_wr, b_done, b_ovf, b_perr;
    logic [15:0] b_addr;
    logic [7:0]  b_data;

    ace_snapshot_unpacker dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(a_wait),
        .loader_en(a_en), .loader_addr(a_addr), .loader_data(a_data),
        .loader_wr(a_wr), .done(a_done), .overflow(a_ovf), .proto_err(a_perr)
    );

    ace_snapshot_unpacker #(.MAX_LEN(SMAX)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(b_wait),
        .loader_en(b_en), .loader_addr(b_addr), .loader_data(b_data),
        .loader_wr(b_wr), .done(b_done), .overflow(b_ovf), .proto_err(b_perr)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t q_a[$];
    wr_t q_b[$];
    int  checks = 0;
    int  passes = 0;
    int  w_from = 1;
    int  w_to   = 0;
    int  k      = 0;   // output bytes produced in the current download

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitors, sampled on the falling edge
    always @(negedge clk_sys) begin
        wr_t e;
        logic expw;
        if (reset_n) begin
            if (a_wr) begin
                if (q_a.size() == 0) chk("a_unexpected_wr", {16'd0, a_addr}, 32'hFFFF_FFFF);
                else begin
                    e = q_a.pop_front();
                    chk("a_wr_cycle", cyc, e.c);
                    chk("a_wr_addr", {16'd0, a_addr}, {16'd0, e.addr});
                    chk("a_wr_data", {24'd0, a_data}, {24'd0, e.data});
                end
            end
            if (b_wr) begin
                if (q_b.size() == 0) chk("b_unexpected_wr", {16'd0, b_addr}, 32'hFFFF_FFFF);
                else begin
                    e = q_b.pop_front();
                    chk("b_wr_cycle", cyc, e.c);
                    chk("b_wr_addr", {16'd0, b_addr}, {16'd0, e.addr});
                    chk("b_wr_data", {24'd0, b_data}, {24'd0, e.data});
                end
            end
            expw = (cyc >= w_from) && (cyc <= w_to);
            if (expw || a_wait) chk("a_wait", {31'd0, a_wait}, {31'd0, expw});
            if (expw || b_wait) chk("b_wait", {31'd0, b_wait}, {31'd0, expw});
        end
    end

    // Model: the k-th output byte of a download lands at BASE+k unless the
    // window of that instance is already full
    task automatic emit(input logic [7:0] b, input int c);
        wr_t e;
        e.c = c;
        e.addr = ACE_RAM_BASE + 16'(k);
        e.data = b;
        if (k < int'(ACE_RAM_LEN)) q_a.push_back(e);
        if (k < int'(SMAX)) q_b.push_back(e);
        k++;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (a_wait && guard < 1000) begin
            @(posedge clk_sys); #1;
            guard++;
        end
        if (guard >= 1000) chk("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic [7:0] b, output int n);
        wait_ready();
        ioctl_wr = 1'b1;
        ioctl_dout = b;
        n = cyc;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic tok_run(input int cnt, input logic [7:0] b);
        int n;
        send(ACE_ESC, n); gap();
        send(8'(cnt), n); gap();
        send(b, n);
        w_from = n + 1;
        w_to = n + cnt;
        for (int i = 0; i < cnt; i++) emit(b, n + 1 + i);
        gap();
    endtask

    task automatic tok_lit(input logic [7:0] b);
        int n;
        if (b == ACE_ESC) tok_run(1, b);
        else begin
            send(b, n);
            emit(b, n + 1);
            gap();
        end
    endtask

    task automatic tok_end();
        int n;
        send(ACE_ESC, n); gap();
        send(8'h00, n); gap();
    endtask

    task automatic dl_start();
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        k = 0;
    endtask

    task automatic dl_end(input logic exp_done, input logic exp_perr);
        int ka, kb;
        wait_ready();
        ioctl_download = 1'b0;
        repeat (3) begin
            @(posedge clk_sys); #1;
        end
        ka = (k < int'(ACE_RAM_LEN)) ? k : int'(ACE_RAM_LEN);
        kb = (k < int'(SMAX)) ? k : int'(SMAX);
        chk("done", {31'd0, a_done}, {31'd0, exp_done});
        chk("proto_err", {31'd0, a_perr}, {31'd0, exp_perr});
        chk("a_overflow", {31'd0, a_ovf}, {31'd0, (k > int'(ACE_RAM_LEN))});
        chk("b_overflow", {31'd0, b_ovf}, {31'd0, (k > int'(SMAX))});
        chk("b_done", {31'd0, b_done}, {31'd0, exp_done});
        chk("a_end_addr", {16'd0, a_addr}, 32'(ACE_RAM_BASE) + 32'(ka));
        chk("b_end_addr", {16'd0, b_addr}, 32'(ACE_RAM_BASE) + 32'(kb));
        chk("idle_wait", {30'd0, a_wait, b_wait}, 32'd0);
        chk("idle_en", {30'd0, a_en, b_en}, 32'd0);
        chk("a_pending", q_a.size(), 32'd0);
        chk("b_pending", q_b.size(), 32'd0);
        q_a.delete();
        q_b.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a_ctl"}, {26'd0, a_wait, a_en, a_wr, a_done, a_ovf, a_perr}, 32'd0);
        chk({tag, "_b_ctl"}, {26'd0, b_wait, b_en, b_wr, b_done, b_ovf, b_perr}, 32'd0);
        chk({tag, "_a_addr"}, {16'd0, a_addr}, {16'd0, ACE_RAM_BASE});
        chk({tag, "_b_addr"}, {16'd0, b_addr}, {16'd0, ACE_RAM_BASE});
        chk({tag, "_data"}, {16'd0, a_data, b_data}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] b;
        logic ended;

        repeat (3) @(posedge clk_sys);
        #1;
        chk_reset("reset");
        reset_n = 1'b1;
        @(posedge clk_sys); #1;

        // Two literals then end marker
        dl_start();
        tok_lit(8'h41); tok_lit(8'h42); tok_end();
        dl_end(1'b1, 1'b0);

        // Run of four, overflowing nothing in A and exactly filling B
        dl_start();
        tok_run(4, 8'h55); tok_end();
        dl_end(1'b1, 1'b0);

        // Escaped literal ED followed by a literal zero (not an end marker)
        dl_start();
        tok_lit(8'hED); tok_lit(8'h00);
        chk("no_early_done", {31'd0, a_done}, 32'd0);
        tok_end();
        dl_end(1'b1, 1'b0);

        // Run of six: B suppresses the last two and holds at BASE+4
        dl_start();
        tok_run(6, 8'hAA); tok_end();
        dl_end(1'b1, 1'b0);

        // Byte pushed during a run is dropped; run finishes its full count
        dl_start();
        send(ACE_ESC, n);
        send(8'd5, n);
        send(8'h33, n);
        w_from = n + 1;
        w_to = n + 5;
        for (int i = 0; i < 5; i++) emit(8'h33, n + 1 + i);
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b1;
        ioctl_dout = 8'h99;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        chk("perr_in_run", {31'd0, a_perr}, 32'd1);
        tok_end();
        dl_end(1'b1, 1'b1);

        // Download drops right after the count byte
        dl_start();
        send(ACE_ESC, n);
        send(8'd3, n);
        ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        chk("drop_wait_wr", {30'd0, a_wait, a_wr}, 32'd0);
        dl_end(1'b0, 1'b1);

        // Randomized downloads
        for (int d = 0; d < 10; d++) begin
            dl_start();
            ended = 1'b0;
            for (int t = 0; t < int'($urandom_range(3, 10)); t++) begin
                if ($urandom_range(0, 2) == 0) tok_run(int'($urandom_range(1, 12)), 8'($urandom_range(0, 255)));
                else begin
                    b = ($urandom_range(0, 3) == 0) ? ACE_ESC : 8'($urandom_range(0, 255));
                    tok_lit(b);
                end
            end
            if ($urandom_range(0, 4) != 0) begin
                tok_end();
                ended = 1'b1;
                // trailing bytes after the end marker must be ignored
                for (int j = 0; j < 3; j++) begin
                    send(8'($urandom_range(0, 255)), n);
                    gap();
                end
            end
            dl_end(ended, 1'b0);
        end

        // Reset asserted in the middle of a long run
        dl_start();
        send(ACE_ESC, n);
        send(8'd20, n);
        send(8'h77, n);
        w_from = n + 1;
        w_to = n + 20;
        for (int i = 0; i < 20; i++) emit(8'h77, n + 1 + i);
        repeat (5) begin
            @(posedge clk_sys); #1;
        end
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        q_a.delete();
        q_b.delete();
        w_from = 1;
        w_to = 0;
        chk_reset("midrun_reset");
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk_sys); #1;
        end
        chk_reset("after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
